// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: watering FSM choosing sprinkler/drip bursts, soak pauses and low-tank lockout
module irrigation_sequencer #(
  parameter int SPRINKLER_TIME = 10,
  parameter int DRIP_TIME = 20,
  parameter int SOAK_TIME = 5,
  parameter int CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       soil_dry_i,
  input  logic       soil_critical_i,
  input  logic       tank_low_i,
  input  logic       manual_stop_i,
  output logic       sprinkler_status_o,
  output logic       drip_status_o,
  output logic       irrigation_status_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [7:0] cycle_count_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SPRINKLE = 3'd1;
  localparam logic [2:0] DRIP = 3'd2;
  localparam logic [2:0] SOAK = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;
  localparam logic [CNT_W-1:0] SPR_N = CNT_W'(SPRINKLER_TIME);
  localparam logic [CNT_W-1:0] DRIP_N = CNT_W'(DRIP_TIME);
  localparam logic [CNT_W-1:0] SOAK_N = CNT_W'(SOAK_TIME);
  logic [2:0] state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] cyc_n;
  logic last;
  assign last = tick_i && cnt == CNT_W'(1);
  always_comb begin
    state_n = state_o;
    cnt_n = cnt;
    cyc_n = cycle_count_o;
    if (tank_low_i && state_o != FAULT) state_n = FAULT;
    else
      case (state_o)
        FAULT: state_n = (tick_i && !tank_low_i) ? IDLE : FAULT;
        IDLE:
          if (soil_dry_i && !manual_stop_i) begin
            state_n = soil_critical_i ? SPRINKLE : DRIP;
            cnt_n = soil_critical_i ? SPR_N : DRIP_N;
          end
        SPRINKLE, DRIP:
          if (manual_stop_i) state_n = IDLE;
          else if (!soil_dry_i) begin
            state_n = SOAK;
            cnt_n = SOAK_N;
          end else if (state_o == DRIP && soil_critical_i) begin
            state_n = SPRINKLE;
            cnt_n = SPR_N;
          end else if (last) begin
            state_n = SOAK;
            cnt_n = SOAK_N;
            cyc_n = cycle_count_o + {7'd0, ~&cycle_count_o};
          end else if (tick_i) cnt_n = cnt - CNT_W'(1);
        SOAK:
          if (manual_stop_i || last) state_n = IDLE;
          else if (tick_i) cnt_n = cnt - CNT_W'(1);
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_o <= IDLE;
      cnt <= '0;
      cycle_count_o <= '0;
      sprinkler_status_o <= 1'b0;
      drip_status_o <= 1'b0;
      irrigation_status_o <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      state_o <= state_n;
      cnt <= cnt_n;
      cycle_count_o <= cyc_n;
      sprinkler_status_o <= state_n == SPRINKLE;
      drip_status_o <= state_n == DRIP;
      irrigation_status_o <= state_n == SPRINKLE || state_n == DRIP;
      fault_o <= state_n == FAULT;
    end
  end
endmodule
